// File: rtl/md_bus_resolver_if.sv
// Bundle of driver inputs and resolved-net outputs for md_bus_resolver.
// The master modport is the driver side (board model / bench); the slave modport is the resolver.
interface md_bus_resolver_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_DRV = 4,
    parameter int CNT_W   = 8
);
    logic [NUM_DRV*WIDTH-1:0] drv_o;
    logic [NUM_DRV*WIDTH-1:0] drv_d;
    logic                     clr;
    logic [WIDTH-1:0]         bus;
    logic [WIDTH-1:0]         bus_driven;
    logic                     contention;
    logic [NUM_DRV-1:0]       culprit_mask;
    logic [CNT_W-1:0]         contention_cnt;

    modport master (
        output drv_o, drv_d, clr,
        input  bus, bus_driven, contention, culprit_mask, contention_cnt
    );

    modport slave (
        input  drv_o, drv_d, clr,
        output bus, bus_driven, contention, culprit_mask, contention_cnt
    );
endinterface

// File: rtl/md_bus_resolver.sv
// Registered multi-driver net resolver: wired-OR (keeper or pull) or open-drain wired-AND,
// with per-cycle contention flag, sticky culprit mask and saturating contention counter.

// One net bit: combines every driver's active/value pair for that bit.
module md_bus_resolver_bit #(
    parameter int NUM_DRV = 4,
    parameter int MODE    = 0
) (
    input  logic [NUM_DRV-1:0] act_i,
    input  logic [NUM_DRV-1:0] val_i,
    input  logic               idle_i,
    output logic               nxt_o,
    output logic               driven_o,
    output logic               cont_o,
    output logic [NUM_DRV-1:0] inv_o
);
    logic any_hi;
    logic any_lo;

    always_comb begin
        any_hi   = |(act_i & val_i);
        any_lo   = |(act_i & ~val_i);
        driven_o = |act_i;
        nxt_o    = idle_i;
        cont_o   = 1'b0;
        if (driven_o) begin
            // Open-drain: an active driver holding 1 is indistinguishable from a released one.
            nxt_o = (MODE == 2) ? ~any_lo : any_hi;
        end
        if (MODE != 2) begin
            cont_o = any_hi & any_lo;
        end
        inv_o = act_i & {NUM_DRV{cont_o}};
    end
endmodule

module md_bus_resolver #(
    parameter int               WIDTH    = 16,
    parameter int               NUM_DRV  = 4,
    parameter int               MODE     = 0,
    parameter logic [WIDTH-1:0] PULL_VAL = '1,
    parameter logic [WIDTH-1:0] RST_VAL  = '1,
    parameter int               CNT_W    = 8
) (
    input  logic              MCLK,
    input  logic              reset_n,
    md_bus_resolver_if.slave  bif
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0][NUM_DRV-1:0] act_t;
    logic [WIDTH-1:0][NUM_DRV-1:0] val_t;
    logic [WIDTH-1:0][NUM_DRV-1:0] inv_t;
    logic [WIDTH-1:0]              idle;
    logic [WIDTH-1:0]              bus_d;
    logic [WIDTH-1:0]              driven_d;
    logic [WIDTH-1:0]              cont_b;
    logic [NUM_DRV-1:0]            inv;
    logic                          cont_d;
    logic [NUM_DRV-1:0]            mask_d;
    logic [CNT_W-1:0]              cnt_d;

    logic [WIDTH-1:0]              bus_q;
    logic [WIDTH-1:0]              driven_q;
    logic                          cont_q;
    logic [NUM_DRV-1:0]            mask_q;
    logic [CNT_W-1:0]              cnt_q;

    // Regroup the driver-major input vectors into bit-major slices.
    always_comb begin
        act_t = '0;
        val_t = '0;
        for (int i = 0; i < NUM_DRV; i++) begin
            for (int b = 0; b < WIDTH; b++) begin
                act_t[b][i] = ~bif.drv_d[i*WIDTH + b];
                val_t[b][i] = bif.drv_o[i*WIDTH + b];
            end
        end
    end

    // Undriven bits: open-drain floats high, pull mode takes PULL_VAL, keeper holds.
    always_comb begin
        if (MODE == 2) begin
            idle = '1;
        end else if (MODE == 1) begin
            idle = PULL_VAL;
        end else begin
            idle = bus_q;
        end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        md_bus_resolver_bit #(
            .NUM_DRV (NUM_DRV),
            .MODE    (MODE)
        ) u_bit (
            .act_i    (act_t[b]),
            .val_i    (val_t[b]),
            .idle_i   (idle[b]),
            .nxt_o    (bus_d[b]),
            .driven_o (driven_d[b]),
            .cont_o   (cont_b[b]),
            .inv_o    (inv_t[b])
        );
    end

    always_comb begin
        inv = '0;
        for (int b = 0; b < WIDTH; b++) begin
            inv = inv | inv_t[b];
        end
        cont_d = |cont_b;
    end

    // clr is applied first so a contention in the same cycle becomes the first recorded event.
    always_comb begin
        mask_d = mask_q;
        cnt_d  = cnt_q;
        if (bif.clr) begin
            mask_d = '0;
            cnt_d  = '0;
        end
        if (cont_d) begin
            if (mask_d == '0) begin
                mask_d = inv;
            end
            if (cnt_d != CNT_MAX) begin
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (!reset_n) begin
            bus_q    <= RST_VAL;
            driven_q <= '0;
            cont_q   <= 1'b0;
            mask_q   <= '0;
            cnt_q    <= '0;
        end else begin
            bus_q    <= bus_d;
            driven_q <= driven_d;
            cont_q   <= cont_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bif.bus            = bus_q;
    assign bif.bus_driven     = driven_q;
    assign bif.contention     = cont_q;
    assign bif.culprit_mask   = mask_q;
    assign bif.contention_cnt = cnt_q;
endmodule
